// File: rtl/tqv_peri_bus_arbiter.sv
// Peripheral bus front-end for tinyQV: decodes the CPU peripheral address into slots,
// steers byte-lane strobes to the selected slot and runs the read handshake with a timeout.
module tqv_peri_bus_arbiter #(
   parameter int          NUM_SLOTS      = 16,
   parameter int          SLOT_ADDR_BITS = 6,
   parameter int          ADDR_W         = 11,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ADDR_W-1:0]           addr_in,
   input  logic [31:0]                 data_in,
   input  logic [1:0]                  data_write_n,
   input  logic [1:0]                  data_read_n,
   input  logic                        data_read_complete,
   output logic [31:0]                 data_out,
   output logic                        data_ready,
   output logic [SLOT_ADDR_BITS-1:0]   slot_address,
   output logic [2*NUM_SLOTS-1:0]      slot_write_n,
   output logic [2*NUM_SLOTS-1:0]      slot_read_n,
   input  logic [32*NUM_SLOTS-1:0]     slot_data,
   input  logic [NUM_SLOTS-1:0]        slot_ready,
   output logic [NUM_SLOTS-1:0]        slot_sel,
   output logic                        timeout_pulse,
   output logic [7:0]                  err_count
);

   localparam int IDX_W      = ADDR_W - SLOT_ADDR_BITS;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int LAST_I     = TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLD
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   wait_cnt;
   logic [IDX_W-1:0]   idx;
   logic               mapped;
   logic               read_req;
   logic               write_req;
   logic [31:0]        sel_data;
   logic               sel_ready;

   // Slots take write data straight off the CPU bus; it is not routed through here.
   logic unused_data_in;
   assign unused_data_in = ^data_in;

   assign idx          = addr_in[ADDR_W-1:SLOT_ADDR_BITS];
   assign mapped       = (32'(idx) < NUM_SLOTS);
   assign slot_address = addr_in[SLOT_ADDR_BITS-1:0];
   assign read_req     = (data_read_n != 2'b11);
   assign write_req    = (data_write_n != 2'b11);
   assign data_ready   = (state == ST_HOLD) | write_req;

   // NOTE: every output of this block gets a default first so no path leaves it unassigned
   // (which would infer a latch).
   always_comb begin
      slot_sel     = '0;
      slot_write_n = '1;
      slot_read_n  = '1;
      sel_data     = '0;
      sel_ready    = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (mapped && (idx == IDX_W'(i))) begin
            slot_sel[i]            = 1'b1;
            slot_write_n[2*i +: 2] = data_write_n;
            // HOLD masks the strobe so a slot with read side effects is not read twice.
            slot_read_n[2*i +: 2]  = (state == ST_HOLD) ? 2'b11 : data_read_n;
            sel_data               = slot_data[32*i +: 32];
            sel_ready              = slot_ready[i];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         data_out      <= '0;
         wait_cnt      <= '0;
         err_count     <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (read_req) begin
                  if (!mapped) begin
                     data_out <= '0;
                     state    <= ST_HOLD;
                  end else if (sel_ready) begin
                     data_out <= sel_data;
                     state    <= ST_HOLD;
                  end else begin
                     wait_cnt <= '0;
                     state    <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               if (!read_req) begin
                  state <= ST_IDLE;
               end else if (sel_ready) begin
                  // Ready takes priority over a timeout landing on the same cycle.
                  data_out <= sel_data;
                  state    <= ST_HOLD;
               end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                  data_out      <= ERR_DATA;
                  timeout_pulse <= 1'b1;
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
                  state <= ST_HOLD;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_HOLD: begin
               if (data_read_complete || !read_req) begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
